// File: rtl/branch_commit_reporter.sv
// In-order retirement of conditional branches/JALs: tracks predictions, captures
// out-of-order resolutions, emits predictor training and mispredict redirect.
module branch_commit_reporter #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_rdy,
    input  logic             i_alloc_valid,
    input  logic [31:0]      i_alloc_pc,
    input  logic             i_alloc_pred_taken,
    input  logic [31:0]      i_alloc_pred_target,
    output logic [IDX_W-1:0] o_alloc_tag,
    output logic             o_full,
    input  logic             i_res_valid,
    input  logic [IDX_W-1:0] i_res_tag,
    input  logic             i_res_taken,
    input  logic [31:0]      i_res_target,
    output logic             o_rob_commit_pc_arrived,
    output logic [31:0]      o_rob_commit_pc,
    output logic             o_hit_res,
    output logic             o_commit_taken,
    output logic             o_mispredict,
    output logic [31:0]      o_redirect_pc
);

    localparam int unsigned CNT_W = IDX_W + 1;

    logic [31:0]      r_pc          [DEPTH];
    logic             r_pred_taken  [DEPTH];
    logic [31:0]      r_pred_target [DEPTH];
    logic             r_taken       [DEPTH];
    logic [31:0]      r_target      [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_resolved;
    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             r_arrived;
    logic [31:0]      r_commit_pc;
    logic             r_hit;
    logic             r_commit_taken;
    logic             r_mispredict;
    logic [31:0]      r_redirect_pc;

    logic             w_commit;
    logic             w_hit;
    logic             w_flush;
    logic             w_alloc;
    logic             w_res;
    logic [31:0]      w_actual_next;

    // Head-of-buffer retirement decision, all from pre-edge state
    always_comb begin
        w_commit      = r_valid[r_head] & r_resolved[r_head];
        w_actual_next = r_taken[r_head] ? r_target[r_head] : 32'(r_pc[r_head] + 32'd4);
        w_hit         = (r_pred_taken[r_head] == r_taken[r_head]) &&
                        (r_pred_target[r_head] == w_actual_next);
        w_flush       = w_commit & ~w_hit;
        w_alloc       = i_alloc_valid & ~o_full;
        w_res         = i_res_valid & r_valid[i_res_tag];
    end

    assign o_full      = (r_count == CNT_W'(DEPTH));
    assign o_alloc_tag = r_tail;

    // Entry payload; no reset needed since valid/resolved gate every use
    always_ff @(posedge clk) begin
        if (!rst && i_rdy && !w_flush) begin
            if (w_alloc) begin
                r_pc[r_tail]          <= i_alloc_pc;
                r_pred_taken[r_tail]  <= i_alloc_pred_taken;
                r_pred_target[r_tail] <= i_alloc_pred_target;
            end
            if (w_res) begin
                r_taken[i_res_tag]  <= i_res_taken;
                r_target[i_res_tag] <= i_res_target;
            end
        end
    end

    // Pointers, occupancy and per-entry flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_valid    <= '0;
            r_resolved <= '0;
        end else if (i_rdy) begin
            if (w_flush) begin
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
                r_valid    <= '0;
                r_resolved <= '0;
            end else begin
                if (w_commit) begin
                    r_valid[r_head]    <= 1'b0;
                    r_resolved[r_head] <= 1'b0;
                    r_head             <= r_head + IDX_W'(1);
                end
                if (w_alloc) begin
                    r_valid[r_tail]    <= 1'b1;
                    r_resolved[r_tail] <= 1'b0;
                    r_tail             <= r_tail + IDX_W'(1);
                end
                if (w_res) begin
                    r_resolved[i_res_tag] <= 1'b1;
                end
                case ({w_alloc, w_commit})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Registered commit report; pulses drop whenever no commit fires
    always_ff @(posedge clk) begin
        if (rst) begin
            r_arrived      <= 1'b0;
            r_commit_pc    <= '0;
            r_hit          <= 1'b0;
            r_commit_taken <= 1'b0;
            r_mispredict   <= 1'b0;
            r_redirect_pc  <= '0;
        end else if (i_rdy) begin
            r_arrived    <= w_commit;
            r_mispredict <= w_flush;
            if (w_commit) begin
                r_commit_pc    <= r_pc[r_head];
                r_hit          <= w_hit;
                r_commit_taken <= r_taken[r_head];
            end
            if (w_flush) begin
                r_redirect_pc <= w_actual_next;
            end
        end else begin
            r_arrived    <= 1'b0;
            r_mispredict <= 1'b0;
        end
    end

    assign o_rob_commit_pc_arrived = r_arrived;
    assign o_rob_commit_pc         = r_commit_pc;
    assign o_hit_res               = r_hit;
    assign o_commit_taken          = r_commit_taken;
    assign o_mispredict            = r_mispredict;
    assign o_redirect_pc           = r_redirect_pc;

endmodule

// File: tb/tb_branch_commit_reporter.sv
// Self-checking bench for branch_commit_reporter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_branch_commit_reporter;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        av, apt, rv, rtk;
    logic [31:0] apc, aptg, rtg;
    logic [3:0]  rtag;
    logic [3:0]  o_tag;
    logic        o_full, o_arr, o_hit, o_tk, o_mis;
    logic [31:0] o_pc, o_red;

    int n_checks = 0;
    int n_errors = 0;

    branch_commit_reporter #(.DEPTH(16), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .i_rdy(rdy),
        .i_alloc_valid(av), .i_alloc_pc(apc), .i_alloc_pred_taken(apt),
        .i_alloc_pred_target(aptg), .o_alloc_tag(o_tag), .o_full(o_full),
        .i_res_valid(rv), .i_res_tag(rtag), .i_res_taken(rtk), .i_res_target(rtg),
        .o_rob_commit_pc_arrived(o_arr), .o_rob_commit_pc(o_pc), .o_hit_res(o_hit),
        .o_commit_taken(o_tk), .o_mispredict(o_mis), .o_redirect_pc(o_red)
    );

    always #5 clk = ~clk;

    // Reference model: in-flight branches in program order
    typedef struct {
        logic [3:0]  tag;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptg;
        bit          res;
        logic        tk;
        logic [31:0] tg;
    } ent_t;

    ent_t        q[$];
    int          m_tail = 0;
    logic        e_arr = 0, e_hit = 0, e_tk = 0, e_mis = 0;
    logic [31:0] e_pc = 0, e_red = 0;

    function automatic logic [72:0] dut_vec();
        return {o_arr, o_pc, o_hit, o_tk, o_mis, o_red, o_full, o_tag};
    endfunction

    function automatic logic [72:0] mk(logic a, logic [31:0] pc, logic h, logic t,
                                       logic m, logic [31:0] r, logic f, logic [3:0] tg);
        return {a, pc, h, t, m, r, f, tg};
    endfunction

    function automatic logic [72:0] model_vec();
        return {e_arr, e_pc, e_hit, e_tk, e_mis, e_red, (q.size() == DEPTH), 4'(m_tail)};
    endfunction

    // Advance the model by one edge using the current inputs, then clock the DUT
    task automatic tick();
        bit          full_m;
        bit          commit;
        bit          hit;
        logic [31:0] nxt;
        full_m = (q.size() == DEPTH);
        hit    = 1'b1;
        if (rst) begin
            q.delete(); m_tail = 0;
            e_arr = 0; e_hit = 0; e_tk = 0; e_mis = 0; e_pc = 0; e_red = 0;
        end else if (!rdy) begin
            e_arr = 0; e_mis = 0;
        end else begin
            commit = (q.size() > 0) && q[0].res;
            e_arr  = commit;
            e_mis  = 0;
            if (commit) begin
                nxt   = q[0].tk ? q[0].tg : q[0].pc + 32'd4;
                hit   = (q[0].pt == q[0].tk) && (q[0].ptg == nxt);
                e_pc  = q[0].pc;
                e_hit = hit;
                e_tk  = q[0].tk;
                if (!hit) begin
                    e_mis = 1;
                    e_red = nxt;
                end
                void'(q.pop_front());
            end
            if (commit && !hit) begin
                q.delete(); m_tail = 0;
            end else begin
                if (rv) begin
                    foreach (q[i]) if (q[i].tag == rtag) begin
                        q[i].res = 1; q[i].tk = rtk; q[i].tg = rtg;
                    end
                end
                if (av && !full_m) begin
                    q.push_back('{tag: 4'(m_tail), pc: apc, pt: apt, ptg: aptg,
                                  res: 1'b0, tk: 1'b0, tg: 32'd0});
                    m_tail = (m_tail + 1) % DEPTH;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        av = 0; rv = 0; apc = 0; apt = 0; aptg = 0; rtag = 0; rtk = 0; rtg = 0;
    endtask

    task automatic do_reset();
        idle(); rdy = 1; rst = 1; tick(); rst = 0;
    endtask

    task automatic alloc(logic [31:0] pc, logic pt, logic [31:0] ptg);
        av = 1; apc = pc; apt = pt; aptg = ptg; tick(); idle();
    endtask

    task automatic resolve(logic [3:0] tag, logic tk, logic [31:0] tg);
        rv = 1; rtag = tag; rtk = tk; rtg = tg; tick(); idle();
    endtask

    task automatic test_reset();
        idle(); rdy = 1; rst = 1; tick(); tick(); rst = 0;
        n_checks++;
        if (dut_vec() !== mk(0, 0, 0, 0, 0, 0, 0, 0)) begin
            n_errors++; $display("FAIL reset: got %h want %h", dut_vec(), mk(0, 0, 0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_basic();
        do_reset();
        av = 1; apc = 32'h100; apt = 0; aptg = 32'h104; #1;
        n_checks++;
        if (o_tag !== 4'd0) begin n_errors++; $display("FAIL basic_tag: got %0d want 0", o_tag); end
        tick(); idle();
        resolve(4'd0, 1'b0, 32'h0);
        n_checks++;
        if (dut_vec() !== mk(0, 0, 0, 0, 0, 0, 0, 1)) begin
            n_errors++; $display("FAIL basic_no_bypass: got %h want %h", dut_vec(), mk(0, 0, 0, 0, 0, 0, 0, 1));
        end
        tick();
        n_checks++;
        if (dut_vec() !== mk(1, 32'h100, 1, 0, 0, 0, 0, 1)) begin
            n_errors++; $display("FAIL basic_commit: got %h want %h", dut_vec(), mk(1, 32'h100, 1, 0, 0, 0, 0, 1));
        end
        tick();
        n_checks++;
        if (dut_vec() !== mk(0, 32'h100, 1, 0, 0, 0, 0, 1)) begin
            n_errors++; $display("FAIL basic_pulse_drop: got %h want %h", dut_vec(), mk(0, 32'h100, 1, 0, 0, 0, 0, 1));
        end
    endtask

    task automatic test_in_order();
        logic [31:0] pcs [3];
        pcs[0] = 32'h200; pcs[1] = 32'h204; pcs[2] = 32'h208;
        do_reset();
        for (int i = 0; i < 3; i++) alloc(pcs[i], 1'b0, pcs[i] + 32'd4);
        resolve(4'd2, 1'b0, 32'h0);
        resolve(4'd0, 1'b0, 32'h0);
        n_checks++;
        if (o_arr !== 1'b0) begin n_errors++; $display("FAIL order_early: got %b want 0", o_arr); end
        rv = 1; rtag = 4'd1; rtk = 0; rtg = 0;
        for (int i = 0; i < 3; i++) begin
            tick(); idle();
            n_checks++;
            if (dut_vec() !== mk(1, pcs[i], 1, 0, 0, 0, 0, 3)) begin
                n_errors++; $display("FAIL order_commit%0d: got %h want %h", i, dut_vec(), mk(1, pcs[i], 1, 0, 0, 0, 0, 3));
            end
        end
        tick();
        n_checks++;
        if (o_arr !== 1'b0) begin n_errors++; $display("FAIL order_drain: got %b want 0", o_arr); end
    endtask

    task automatic test_mispredict();
        do_reset();
        alloc(32'h300, 1'b0, 32'h304);
        alloc(32'h310, 1'b0, 32'h314);
        resolve(4'd0, 1'b1, 32'h280);
        tick();
        n_checks++;
        if (dut_vec() !== mk(1, 32'h300, 0, 1, 1, 32'h280, 0, 0)) begin
            n_errors++; $display("FAIL mispred_dir: got %h want %h", dut_vec(), mk(1, 32'h300, 0, 1, 1, 32'h280, 0, 0));
        end
        resolve(4'd1, 1'b0, 32'h0);
        tick();
        n_checks++;
        if (dut_vec() !== mk(0, 32'h300, 0, 1, 0, 32'h280, 0, 0)) begin
            n_errors++; $display("FAIL mispred_flushed: got %h want %h", dut_vec(), mk(0, 32'h300, 0, 1, 0, 32'h280, 0, 0));
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) alloc(32'h1000 + 32'(4 * i), 1'b0, 32'h1004 + 32'(4 * i));
        n_checks++;
        if (dut_vec() !== mk(0, 0, 0, 0, 0, 0, 1, 0)) begin
            n_errors++; $display("FAIL full_set: got %h want %h", dut_vec(), mk(0, 0, 0, 0, 0, 0, 1, 0));
        end
        alloc(32'h9990, 1'b0, 32'h9994);
        n_checks++;
        if (dut_vec() !== mk(0, 0, 0, 0, 0, 0, 1, 0)) begin
            n_errors++; $display("FAIL full_reject: got %h want %h", dut_vec(), mk(0, 0, 0, 0, 0, 0, 1, 0));
        end
        resolve(4'd0, 1'b0, 32'h0);
        tick();
        n_checks++;
        if (dut_vec() !== mk(1, 32'h1000, 1, 0, 0, 0, 0, 0)) begin
            n_errors++; $display("FAIL full_retire: got %h want %h", dut_vec(), mk(1, 32'h1000, 1, 0, 0, 0, 0, 0));
        end
        av = 1; apc = 32'h2000; apt = 0; aptg = 32'h2004; #1;
        n_checks++;
        if (o_tag !== 4'd0) begin n_errors++; $display("FAIL full_wrap_tag: got %0d want 0", o_tag); end
        tick(); idle();
        n_checks++;
        if (dut_vec() !== mk(0, 32'h1000, 1, 0, 0, 0, 1, 1)) begin
            n_errors++; $display("FAIL full_refill: got %h want %h", dut_vec(), mk(0, 32'h1000, 1, 0, 0, 0, 1, 1));
        end
    endtask

    task automatic test_rdy();
        do_reset();
        alloc(32'h400, 1'b0, 32'h404);
        resolve(4'd0, 1'b0, 32'h0);
        rdy = 0; av = 1; apc = 32'h480; aptg = 32'h484;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (dut_vec() !== mk(0, 0, 0, 0, 0, 0, 0, 1)) begin
                n_errors++; $display("FAIL rdy_freeze%0d: got %h want %h", i, dut_vec(), mk(0, 0, 0, 0, 0, 0, 0, 1));
            end
        end
        rdy = 1; idle(); tick();
        n_checks++;
        if (dut_vec() !== mk(1, 32'h400, 1, 0, 0, 0, 0, 1)) begin
            n_errors++; $display("FAIL rdy_resume: got %h want %h", dut_vec(), mk(1, 32'h400, 1, 0, 0, 0, 0, 1));
        end
    endtask

    task automatic test_target_and_reset();
        do_reset();
        alloc(32'h4F0, 1'b1, 32'h500);
        resolve(4'd0, 1'b1, 32'h504);
        tick();
        n_checks++;
        if (dut_vec() !== mk(1, 32'h4F0, 0, 1, 1, 32'h504, 0, 0)) begin
            n_errors++; $display("FAIL wrong_target: got %h want %h", dut_vec(), mk(1, 32'h4F0, 0, 1, 1, 32'h504, 0, 0));
        end
        alloc(32'h600, 1'b0, 32'h604);
        resolve(4'd0, 1'b0, 32'h0);
        rst = 1; av = 1; apc = 32'h700; aptg = 32'h704;
        tick();
        n_checks++;
        if (dut_vec() !== mk(0, 0, 0, 0, 0, 0, 0, 0)) begin
            n_errors++; $display("FAIL midreset: got %h want %h", dut_vec(), mk(0, 0, 0, 0, 0, 0, 0, 0));
        end
        rst = 0; idle(); tick();
        n_checks++;
        if (dut_vec() !== mk(0, 0, 0, 0, 0, 0, 0, 0)) begin
            n_errors++; $display("FAIL midreset_gone: got %h want %h", dut_vec(), mk(0, 0, 0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_random();
        int k;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst  = ($urandom_range(0, 299) == 0);
            rdy  = ($urandom_range(0, 9) != 0);
            av   = ($urandom_range(0, 99) < 55);
            apc  = $urandom & 32'hFFFF_FFFC;
            if (cyc % 500 == 7) apc = 32'hFFFF_FFFC;
            apt  = $urandom_range(0, 1);
            aptg = apt ? ($urandom & 32'h0000_FFFC) : apc + 32'd4;
            if ($urandom_range(0, 19) == 0) aptg = $urandom;
            rv   = 0;
            if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
                k    = $urandom_range(0, q.size() - 1);
                rv   = 1;
                rtag = q[k].tag;
                rtk  = ($urandom_range(0, 9) < 8) ? q[k].pt : ~q[k].pt;
                rtg  = (rtk && q[k].pt && $urandom_range(0, 9) < 8) ? q[k].ptg : $urandom;
            end else if ($urandom_range(0, 3) == 0) begin
                rv = 1; rtag = 4'($urandom); rtk = $urandom_range(0, 1); rtg = $urandom;
            end
            tick();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_errors++; $display("FAIL random_cyc%0d: got %h want %h", cyc, dut_vec(), model_vec());
            end
        end
        idle(); rst = 0; rdy = 1;
    endtask

    initial begin
        idle(); rdy = 1; rst = 1;
        test_reset();
        test_basic();
        test_in_order();
        test_mispredict();
        test_full();
        test_rdy();
        test_target_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
